// File: rtl/cdc_req_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing the single-outstanding CDC bridge port among N_REQ requesters.
// Optional watchdog (macro CDC_ARB_TIMEOUT_EN) answers with an error response if the bridge never replies.
//
// state    | meaning
// IDLE     | arbitrating; accepts one request per grant
// ISSUE    | presenting captured request to the bridge
// WAIT     | waiting for the bridge response
// RESP     | returning response to the granted requester
// DRAIN    | after a watchdog fire: swallow the late bridge response
module cdc_req_arbiter #(
    parameter int N_REQ          = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk1,
    input  logic                rst_ck1,
    input  logic [N_REQ-1:0]    req_vld,
    output logic [N_REQ-1:0]    req_rdy,
    input  logic [N_REQ*24-1:0] req_addr,
    input  logic [N_REQ*32-1:0] req_data,
    input  logic [N_REQ*8-1:0]  req_op,
    output logic [N_REQ-1:0]    resp_vld,
    input  logic [N_REQ-1:0]    resp_rdy,
    output logic [23:0]         resp_addr,
    output logic [31:0]         resp_data,
    output logic [7:0]          resp_op,
    output logic                m_req_vld,
    input  logic                m_req_rdy,
    output logic [23:0]         m_req_addr,
    output logic [31:0]         m_req_data,
    output logic [7:0]          m_req_op,
    input  logic                m_resp_vld,
    output logic                m_resp_rdy,
    input  logic [23:0]         m_resp_addr,
    input  logic [31:0]         m_resp_data,
    input  logic [7:0]          m_resp_op,
    output logic                busy,
    output logic                timeout_err
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("cdc_req_arbiter: N_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("cdc_req_arbiter: TIMEOUT_CYCLES must be 2..65535");
    end

`ifdef CDC_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP, ST_DRAIN} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
`endif

    state_t          state, state_nx;
    logic [GW-1:0]   rr_ptr, g_reg, grant_idx;
    logic            grant_found, accept, resp_take;
    logic [23:0]     q_addr, r_addr;
    logic [31:0]     q_data, r_data;
    logic [7:0]      q_op, r_op;
    logic            wd_expire;
`ifdef CDC_ARB_TIMEOUT_EN
    logic [15:0]     wd_cnt;
    logic            wd_fired;
    logic            timeout_q;
`endif

    // First set req_vld bit at or above rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_found && req_vld[(int'(rr_ptr) + i) % N_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = GW'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        resp_take  = 1'b0;
        wd_expire  = 1'b0;
        req_rdy    = '0;
        resp_vld   = '0;
        resp_addr  = '0;
        resp_data  = '0;
        resp_op    = '0;
        m_req_vld  = 1'b0;
        m_req_addr = '0;
        m_req_data = '0;
        m_req_op   = '0;
        m_resp_rdy = 1'b0;
        case (state)
            ST_IDLE: begin
                // Held reset blocks the accept so nothing is granted while the block is cleared.
                if (grant_found && !rst_ck1) begin
                    accept             = 1'b1;
                    req_rdy[grant_idx] = 1'b1;
                    state_nx           = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                m_req_vld  = 1'b1;
                m_req_addr = q_addr;
                m_req_data = q_data;
                m_req_op   = q_op;
                if (m_req_rdy) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                m_resp_rdy = 1'b1;
                if (m_resp_vld) begin
                    resp_take = 1'b1;
                    state_nx  = ST_RESP;
                end
`ifdef CDC_ARB_TIMEOUT_EN
                else if (wd_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    wd_expire = 1'b1;
                    state_nx  = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                resp_vld[g_reg] = 1'b1;
                resp_addr       = r_addr;
                resp_data       = r_data;
                resp_op         = r_op;
                if (resp_rdy[g_reg]) begin
`ifdef CDC_ARB_TIMEOUT_EN
                    state_nx = wd_fired ? ST_DRAIN : ST_IDLE;
`else
                    state_nx = ST_IDLE;
`endif
                end
            end
`ifdef CDC_ARB_TIMEOUT_EN
            ST_DRAIN: begin
                m_resp_rdy = 1'b1;
                if (m_resp_vld) state_nx = ST_IDLE;
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst_ck1) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            g_reg  <= '0;
            q_addr <= '0;
            q_data <= '0;
            q_op   <= '0;
            r_addr <= '0;
            r_data <= '0;
            r_op   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                g_reg  <= grant_idx;
                rr_ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + GW'(1);
                q_addr <= req_addr[int'(grant_idx)*24 +: 24];
                q_data <= req_data[int'(grant_idx)*32 +: 32];
                q_op   <= req_op[int'(grant_idx)*8 +: 8];
            end
            if (resp_take) begin
                r_addr <= m_resp_addr;
                r_data <= m_resp_data;
                r_op   <= m_resp_op;
            end else if (wd_expire) begin
                r_addr <= q_addr;
                r_data <= 32'hDEAD_BEEF;
                r_op   <= 8'hFF;
            end
        end
    end

`ifdef CDC_ARB_TIMEOUT_EN
    // Counter is held at zero outside WAIT, so it restarts on every WAIT entry.
    always_ff @(posedge clk1) begin
        if (rst_ck1) begin
            wd_cnt    <= '0;
            wd_fired  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt    <= (state == ST_WAIT) ? wd_cnt + 16'd1 : 16'd0;
            timeout_q <= wd_expire;
            if (wd_expire)
                wd_fired <= 1'b1;
            else if (state == ST_DRAIN && m_resp_vld)
                wd_fired <= 1'b0;
        end
    end
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_cdc_req_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for cdc_req_arbiter: directed scenarios plus randomized transactions
// checked against a spec-level round-robin/timing model.
module tb_cdc_req_arbiter;
    localparam int N = 3;

    logic            clk1 = 1'b0;
    logic            rst_ck1;
    logic [N-1:0]    req_vld, req_rdy, resp_vld, resp_rdy;
    logic [N*24-1:0] req_addr;
    logic [N*32-1:0] req_data;
    logic [N*8-1:0]  req_op;
    logic [23:0]     resp_addr, m_req_addr, m_resp_addr;
    logic [31:0]     resp_data, m_req_data, m_resp_data;
    logic [7:0]      resp_op, m_req_op, m_resp_op;
    logic            m_req_vld, m_req_rdy, m_resp_vld, m_resp_rdy, busy, timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int ref_ptr = 0;
    int cyc = 0;
    int last_acc = -1;

    cdc_req_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(8)) dut (
        .clk1(clk1), .rst_ck1(rst_ck1),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req_addr(req_addr), .req_data(req_data), .req_op(req_op),
        .resp_vld(resp_vld), .resp_rdy(resp_rdy),
        .resp_addr(resp_addr), .resp_data(resp_data), .resp_op(resp_op),
        .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy),
        .m_req_addr(m_req_addr), .m_req_data(m_req_data), .m_req_op(m_req_op),
        .m_resp_vld(m_resp_vld), .m_resp_rdy(m_resp_rdy),
        .m_resp_addr(m_resp_addr), .m_resp_data(m_resp_data), .m_resp_op(m_resp_op),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Spec-level arbitration: first requesting index searching up from ref_ptr with wrap.
    function automatic int ref_grant(input logic [N-1:0] m);
        for (int i = 0; i < N; i++)
            if (m[(ref_ptr + i) % N]) return (ref_ptr + i) % N;
        return -1;
    endfunction

    task automatic next_cycle();
        @(posedge clk1);
        #1;
    endtask

    task automatic rand_payload(output logic [N*24-1:0] a, output logic [N*32-1:0] d,
                                output logic [N*8-1:0] o);
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        a = r[N*24-1:0];
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        d = r[N*32-1:0];
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        o = r[N*8-1:0];
    endtask

    task automatic check_idle_quiet(input string tag);
        chk({tag, "_m_req_vld"}, 64'(m_req_vld), 64'(0));
        chk({tag, "_m_req_addr"}, 64'(m_req_addr), 64'(0));
        chk({tag, "_resp_vld"}, 64'(resp_vld), 64'(0));
        chk({tag, "_resp_data"}, 64'(resp_data), 64'(0));
    endtask

    // One full transaction, entered and left just after a rising edge.
    task automatic do_txn(input logic [N-1:0] mask,
                          input logic [N*24-1:0] pa, input logic [N*32-1:0] pd,
                          input logic [N*8-1:0] po,
                          input int stall_req, input int resp_dly, input int stall_resp,
                          input logic [23:0] ra, input logic [31:0] rd, input logic [7:0] ro,
                          input int exp_gap);
        int g;
        logic [23:0] ea;
        logic [31:0] ed;
        logic [7:0]  eo;
        logic [N*24-1:0] ta;
        logic [N*32-1:0] td;
        logic [N*8-1:0]  to;
        g  = ref_grant(mask);
        ea = pa[g*24 +: 24];
        ed = pd[g*32 +: 32];
        eo = po[g*8 +: 8];
        req_vld = mask; req_addr = pa; req_data = pd; req_op = po;
        m_req_rdy = 1'b0; m_resp_vld = 1'b0; resp_rdy = '0;
        @(negedge clk1);
        chk("accept_req_rdy", 64'(req_rdy), 64'(1 << g));
        chk("accept_busy", 64'(busy), 64'(0));
        check_idle_quiet("accept");
        if (exp_gap > 0) chk("accept_gap", 64'(cyc - last_acc), 64'(exp_gap));
        last_acc = cyc;
        next_cycle();
        ref_ptr = (g + 1) % N;

        for (int k = 0; k <= stall_req; k++) begin
            rand_payload(ta, td, to);
            req_addr = ta; req_data = td; req_op = to;
            m_req_rdy = (k == stall_req);
            @(negedge clk1);
            chk("issue_m_req_vld", 64'(m_req_vld), 64'(1));
            chk("issue_m_req_addr", 64'(m_req_addr), 64'(ea));
            chk("issue_m_req_data", 64'(m_req_data), 64'(ed));
            chk("issue_m_req_op", 64'(m_req_op), 64'(eo));
            chk("issue_req_rdy", 64'(req_rdy), 64'(0));
            chk("issue_m_resp_rdy", 64'(m_resp_rdy), 64'(0));
            chk("issue_busy", 64'(busy), 64'(1));
            next_cycle();
        end
        m_req_rdy = 1'b0;

        for (int k = 0; k <= resp_dly; k++) begin
            m_resp_vld = (k == resp_dly);
            if (k == resp_dly) begin
                m_resp_addr = ra; m_resp_data = rd; m_resp_op = ro;
            end else begin
                m_resp_addr = 24'($urandom()); m_resp_data = $urandom(); m_resp_op = 8'($urandom());
            end
            @(negedge clk1);
            chk("wait_m_resp_rdy", 64'(m_resp_rdy), 64'(1));
            chk("wait_req_rdy", 64'(req_rdy), 64'(0));
            chk("wait_timeout_err", 64'(timeout_err), 64'(0));
            check_idle_quiet("wait");
            next_cycle();
        end

        for (int k = 0; k <= stall_resp; k++) begin
            m_resp_vld = 1'($urandom());
            m_resp_addr = 24'($urandom()); m_resp_data = $urandom(); m_resp_op = 8'($urandom());
            resp_rdy = N'($urandom());
            resp_rdy[g] = (k == stall_resp);
            @(negedge clk1);
            chk("resp_vld", 64'(resp_vld), 64'(1 << g));
            chk("resp_addr", 64'(resp_addr), 64'(ra));
            chk("resp_data", 64'(resp_data), 64'(rd));
            chk("resp_op", 64'(resp_op), 64'(ro));
            chk("resp_m_resp_rdy", 64'(m_resp_rdy), 64'(0));
            chk("resp_req_rdy", 64'(req_rdy), 64'(0));
            chk("resp_m_req_vld", 64'(m_req_vld), 64'(0));
            next_cycle();
        end
        m_resp_vld = 1'b0; resp_rdy = '0; req_vld = '0;
    endtask

    initial begin
        logic [N*24-1:0] pa;
        logic [N*32-1:0] pd;
        logic [N*8-1:0]  po;
        logic [N-1:0]    mask;
        int g;
        logic [23:0] wa;

        rst_ck1 = 1'b1;
        req_vld = '1; req_addr = '0; req_data = '0; req_op = '0;
        resp_rdy = '1; m_req_rdy = 1'b1; m_resp_vld = 1'b0;
        m_resp_addr = '0; m_resp_data = '0; m_resp_op = '0;

        // Power-on reset
        next_cycle();
        @(negedge clk1);
        chk("rst_req_rdy", 64'(req_rdy), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_m_resp_rdy", 64'(m_resp_rdy), 64'(0));
        chk("rst_timeout_err", 64'(timeout_err), 64'(0));
        check_idle_quiet("rst");
        next_cycle();
        rst_ck1 = 1'b0; req_vld = '0; resp_rdy = '0; m_req_rdy = 1'b0;
        ref_ptr = 0;

        // Round-robin with everyone requesting and zero-latency bridge
        for (int t = 0; t < 6; t++) begin
            rand_payload(pa, pd, po);
            do_txn(3'b111, pa, pd, po, 0, 0, 0, 24'($urandom()), $urandom(), 8'($urandom()),
                   (t == 0) ? -1 : 4);
        end

        // Single request from requester 1
        rand_payload(pa, pd, po);
        pa[1*24 +: 24] = 24'h000010;
        pd[1*32 +: 32] = 32'h12345678;
        po[1*8 +: 8]   = 8'h02;
        do_txn(3'b010, pa, pd, po, 0, 0, 0, 24'h000010, 32'hCAFEF00D, 8'h02, -1);

        // Backpressure on both bridge request and requester response
        rand_payload(pa, pd, po);
        do_txn(3'b101, pa, pd, po, 5, 1, 3, 24'h0ABCDE, 32'h0BADF00D, 8'h5A, -1);

        // Randomized traffic
        for (int t = 0; t < 25; t++) begin
            rand_payload(pa, pd, po);
            mask = N'($urandom_range(1, 7));
            do_txn(mask, pa, pd, po, $urandom_range(0, 2), $urandom_range(0, 3),
                   $urandom_range(0, 2), 24'($urandom()), $urandom(), 8'($urandom()), -1);
        end

        // Reset while in WAIT
        rand_payload(pa, pd, po);
        req_vld = 3'b110; req_addr = pa; req_data = pd; req_op = po;
        g = ref_grant(3'b110);
        @(negedge clk1);
        chk("rstw_accept", 64'(req_rdy), 64'(1 << g));
        next_cycle();
        req_vld = '0; m_req_rdy = 1'b1;
        next_cycle();
        m_req_rdy = 1'b0;
        @(negedge clk1);
        chk("rstw_in_wait", 64'(m_resp_rdy), 64'(1));
        next_cycle();
        rst_ck1 = 1'b1; req_vld = '1; resp_rdy = '1; m_req_rdy = 1'b1; m_resp_vld = 1'b1;
        next_cycle();
        @(negedge clk1);
        chk("rstw_req_rdy", 64'(req_rdy), 64'(0));
        chk("rstw_busy", 64'(busy), 64'(0));
        chk("rstw_m_resp_rdy", 64'(m_resp_rdy), 64'(0));
        chk("rstw_timeout_err", 64'(timeout_err), 64'(0));
        chk("rstw_resp_op", 64'(resp_op), 64'(0));
        chk("rstw_m_req_op", 64'(m_req_op), 64'(0));
        check_idle_quiet("rstw");
        next_cycle();
        rst_ck1 = 1'b0; req_vld = '0; resp_rdy = '0; m_req_rdy = 1'b0; m_resp_vld = 1'b0;
        ref_ptr = 0;
        rand_payload(pa, pd, po);
        do_txn(3'b111, pa, pd, po, 0, 0, 0, 24'h111111, 32'h22222222, 8'h33, -1);

`ifdef CDC_ARB_TIMEOUT_EN
        // Watchdog: bridge never answers within 8 WAIT cycles
        rand_payload(pa, pd, po);
        mask = N'($urandom_range(1, 7));
        g = ref_grant(mask);
        wa = pa[g*24 +: 24];
        req_vld = mask; req_addr = pa; req_data = pd; req_op = po;
        @(negedge clk1);
        chk("wd_accept", 64'(req_rdy), 64'(1 << g));
        next_cycle();
        ref_ptr = (g + 1) % N;
        req_vld = '0; m_req_rdy = 1'b1;
        next_cycle();
        m_req_rdy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk1);
            chk("wd_wait_rdy", 64'(m_resp_rdy), 64'(1));
            chk("wd_wait_no_err", 64'(timeout_err), 64'(0));
            chk("wd_wait_resp_vld", 64'(resp_vld), 64'(0));
            next_cycle();
        end
        m_resp_vld = 1'b1; m_resp_data = 32'h55555555;
        @(negedge clk1);
        chk("wd_timeout_err", 64'(timeout_err), 64'(1));
        chk("wd_resp_vld", 64'(resp_vld), 64'(1 << g));
        chk("wd_resp_addr", 64'(resp_addr), 64'(wa));
        chk("wd_resp_data", 64'(resp_data), 64'(32'hDEAD_BEEF));
        chk("wd_resp_op", 64'(resp_op), 64'(8'hFF));
        chk("wd_late_held", 64'(m_resp_rdy), 64'(0));
        next_cycle();
        resp_rdy = N'(1 << g);
        @(negedge clk1);
        chk("wd_err_pulse", 64'(timeout_err), 64'(0));
        chk("wd_resp_hold", 64'(resp_data), 64'(32'hDEAD_BEEF));
        next_cycle();
        resp_rdy = '0; m_resp_vld = 1'b0; req_vld = '1;
        @(negedge clk1);
        chk("wd_drain_rdy", 64'(m_resp_rdy), 64'(1));
        chk("wd_drain_busy", 64'(busy), 64'(1));
        chk("wd_drain_req_rdy", 64'(req_rdy), 64'(0));
        chk("wd_drain_resp_vld", 64'(resp_vld), 64'(0));
        next_cycle();
        m_resp_vld = 1'b1;
        @(negedge clk1);
        chk("wd_drain_take", 64'(m_resp_rdy), 64'(1));
        next_cycle();
        m_resp_vld = 1'b0; req_vld = '0;
        rand_payload(pa, pd, po);
        do_txn(3'b111, pa, pd, po, 0, 0, 0, 24'h00ABCD, 32'h01234567, 8'h7E, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
